// File: rtl/loctag_cfg_debounce_if.sv
// Config pin bundle between the raw board pins and the loctag core.
// The master side drives the raw pins; the slave side (the debouncer)
// returns the decoded, registered configuration.
interface loctag_cfg_debounce_if;
  logic [3:0] key_n;        // {key_1,key_2,key_3,key_4}, active-low, asynchronous
  logic       mio_10;       // mode-override pin, active-high, asynchronous
  logic [1:0] mode;         // decoded mode
  logic [1:0] mac_q;        // decoded MAC query select
  logic [3:0] keys_db;      // debounced key levels, still active-low
  logic       cfg_valid;    // settle window elapsed since reset
  logic       cfg_changed;  // one-cycle pulse on a {mode,mac_q} change once valid

  modport master (
    output key_n, mio_10,
    input  mode, mac_q, keys_db, cfg_valid, cfg_changed
  );

  modport slave (
    input  key_n, mio_10,
    output mode, mac_q, keys_db, cfg_valid, cfg_changed
  );
endinterface

// File: rtl/loctag_cfg_debounce.sv
// Config front end for the loctag core. Synchronizes and debounces the four
// user keys and pin_mio_10, decodes them into registered mode/mac_q, raises
// cfg_valid after a settle window and pulses cfg_changed on decode changes.
module loctag_cfg_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,  // >= 2
  parameter int SETTLE_CYCLES   = 500000   // >= 1
) (
  input logic                  clk,
  input logic                  reset,
  loctag_cfg_debounce_if.slave cfg
);

  // Five debounced inputs: bits [3:0] are key_n, bit 4 is mio_10.
  localparam int NIN = 5;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  // Idle pin levels: keys released (high), override pin low.
  localparam logic [NIN-1:0] IDLE_LEVEL = 5'b0_1111;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync_q1;
  logic [NIN-1:0] sync_q2;
  logic [NIN-1:0] stable;
  logic [CW-1:0]  cnt [NIN];

  logic [SW-1:0]  settle_cnt;
  logic           valid_q;

  logic           k1, k2, k3, k4;
  logic [1:0]     mode_nxt;
  logic [1:0]     mac_q_nxt;

  logic [1:0]     mode_q;
  logic [1:0]     mac_q_q;
  logic [3:0]     keys_db_q;
  logic           changed_q;

  assign raw = {cfg.mio_10, cfg.key_n};

  // Two-flop synchronizer per pin; nothing sits between the two stages.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= IDLE_LEVEL;
      sync_q2 <= IDLE_LEVEL;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Per-input debounce: a new level must hold DEBOUNCE_CYCLES consecutive
  // cycles; any return to the stable level restarts that input's count.
  // NOTE: the counter array is only five small registers and the restart
  // behaviour depends on it being zero after reset, so it is reset explicitly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= IDLE_LEVEL;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync_q2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_q2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Decode the debounced levels; a pressed key 1/2 overrides mio_10.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    k1        = stable[3];
    k2        = stable[2];
    k3        = stable[1];
    k4        = stable[0];
    mode_nxt  = 2'b00;
    mac_q_nxt = {~k3, ~k4};
    if (!(k1 && k2)) begin
      mode_nxt = {~k1, ~k2};
    end else if (stable[4]) begin
      mode_nxt = 2'b11;
    end
  end

  // Output register; cfg_changed fires with the register update when the
  // decoded configuration moves and the settle window has already passed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= 2'b00;
      mac_q_q   <= 2'b00;
      keys_db_q <= 4'hF;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_nxt;
      mac_q_q   <= mac_q_nxt;
      keys_db_q <= stable[3:0];
      changed_q <= valid_q && ({mode_nxt, mac_q_nxt} != {mode_q, mac_q_q});
    end
  end

  // Settle timer: counts 0..SETTLE_CYCLES-1 after reset, then latches valid
  // and stops until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      valid_q    <= 1'b0;
    end else if (!valid_q) begin
      if (settle_cnt == SETTLE_LAST) begin
        valid_q <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  assign cfg.mode        = mode_q;
  assign cfg.mac_q       = mac_q_q;
  assign cfg.keys_db     = keys_db_q;
  assign cfg.cfg_valid   = valid_q;
  assign cfg.cfg_changed = changed_q;

endmodule

// File: tb/tb_loctag_cfg_debounce.sv
// Directed bench for loctag_cfg_debounce with DEBOUNCE_CYCLES=16,
// SETTLE_CYCLES=32. Expected latency is 16+3 = 19 edges from a pin change
// applied between clock edges.
module tb_loctag_cfg_debounce;

  localparam int DB  = 16;
  localparam int ST  = 32;
  localparam int LAT = DB + 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   pulses;

  loctag_cfg_debounce_if cfg_if ();

  loctag_cfg_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .SETTLE_CYCLES  (ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .cfg  (cfg_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cfg_changed pulses (value is the one held during the prior cycle).
  initial pulses = 0;
  always @(posedge clk) if (cfg_if.cfg_changed === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until mode reaches exp; returns 200 on timeout.
  task automatic wait_mode(input logic [1:0] exp, output int n);
    n = 0;
    while (cfg_if.mode !== exp && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (cfg_if.cfg_valid !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  function automatic int in_window(input int n);
    return (n >= LAT - 1 && n <= LAT + 1) ? LAT : n;
  endfunction

  initial begin
    int n;
    int p0;
    bit bad;
    n_checks = 0;
    n_pass   = 0;

    // ---- 1: reset state and settle timing
    reset         = 1'b1;
    cfg_if.key_n  = 4'hF;
    cfg_if.mio_10 = 1'b0;
    tick(3);
    check("rst_mode",    cfg_if.mode, 2'b00);
    check("rst_mac_q",   cfg_if.mac_q, 2'b00);
    check("rst_keys_db", cfg_if.keys_db, 4'hF);
    check("rst_valid",   cfg_if.cfg_valid, 1'b0);
    check("rst_changed", cfg_if.cfg_changed, 1'b0);
    p0 = pulses;
    @(negedge clk);
    reset = 1'b0;
    wait_valid(n);
    check("t1_valid_cycle", n, ST);
    check("t1_mode", cfg_if.mode, 2'b00);
    tick(2);
    check("t1_no_pulse", pulses - p0, 0);

    // ---- 2: key_1 pressed after valid
    p0 = pulses;
    cfg_if.key_n = 4'b0111;
    wait_mode(2'b10, n);
    check("t2_latency", in_window(n), LAT);
    tick(2);
    check("t2_mac_q",   cfg_if.mac_q, 2'b00);
    check("t2_keys_db", cfg_if.keys_db, 4'b0111);
    check("t2_pulse",   pulses - p0, 1);
    cfg_if.key_n = 4'hF;
    tick(30);
    check("t2_release", cfg_if.mode, 2'b00);

    // ---- 3: key_3 bouncing never qualifies
    p0 = pulses;
    for (int r = 0; r < 5; r++) begin
      cfg_if.key_n = 4'b1101;
      tick(10);
      cfg_if.key_n = 4'hF;
      tick(3);
    end
    tick(30);
    check("t3_mac_q",   cfg_if.mac_q, 2'b00);
    check("t3_keys_db", cfg_if.keys_db, 4'hF);
    check("t3_pulse",   pulses - p0, 0);

    // ---- 4: mio_10 override, then masked by key_2
    p0 = pulses;
    cfg_if.mio_10 = 1'b1;
    tick(30);
    check("t4_mio_mode",  cfg_if.mode, 2'b11);
    check("t4_mio_pulse", pulses - p0, 1);
    p0 = pulses;
    cfg_if.key_n = 4'b1011;
    tick(30);
    check("t4_k2_mode",  cfg_if.mode, 2'b01);
    check("t4_k2_pulse", pulses - p0, 1);
    p0 = pulses;
    cfg_if.mio_10 = 1'b0;
    tick(30);
    check("t4_masked_mode",  cfg_if.mode, 2'b01);
    check("t4_masked_pulse", pulses - p0, 0);
    cfg_if.key_n = 4'hF;
    tick(30);
    check("t4_idle_mode", cfg_if.mode, 2'b00);

    // ---- 5: key_3 and key_4 together -> single step, single pulse
    p0  = pulses;
    bad = 1'b0;
    cfg_if.key_n = 4'b1100;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (cfg_if.mac_q == 2'b01 || cfg_if.mac_q == 2'b10) bad = 1'b1;
    end
    check("t5_no_partial", bad, 1'b0);
    check("t5_mac_q",      cfg_if.mac_q, 2'b11);
    check("t5_keys_db",    cfg_if.keys_db, 4'b1100);
    check("t5_pulse",      pulses - p0, 1);
    cfg_if.key_n = 4'hF;
    tick(30);
    check("t5_release", cfg_if.mac_q, 2'b00);

    // ---- 6: reset in the middle of a key_1 debounce
    cfg_if.key_n = 4'b0111;
    tick(10);
    reset = 1'b1;
    #1;
    check("t6_rst_mode",  cfg_if.mode, 2'b00);
    check("t6_rst_valid", cfg_if.cfg_valid, 1'b0);
    tick(3);
    p0 = pulses;
    @(negedge clk);
    reset = 1'b0;
    wait_mode(2'b10, n);
    check("t6_requalify", in_window(n), LAT);
    check("t6_not_valid_yet", cfg_if.cfg_valid, 1'b0);
    wait_valid(n);
    check("t6_valid_cycle", n, ST - LAT);
    tick(3);
    check("t6_no_pulse", pulses - p0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
